pcs_rx_decode: RTL and testbench

Receive PCS decoder that consumes the aligned, 8b/10b-decoded code-group stream from the receive synchronisation stage. It runs a receive state machine and drives a GMII-style receive interface (RXD/RX_DV/RX_ER). It also captures /C/ configuration ordered sets into a 16-bit register with ability-match detection for the auto-negotiation block, and counts code violations while in sync.

---
 rtl/pcs_rx_decode.sv | 193 +++++++++++++++++++
 tb/tb_pcs_rx_decode.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_decode.sv
// Receive PCS decoder: turns aligned, decoded code groups into GMII receive signals,
// captures /C/ configuration registers with ability match, and counts code violations.
module pcs_rx_decode #(
  parameter int unsigned P_MATCH_CNT = 3
) (
  input  logic        i_Clk,
  input  logic        i_ARst_L,
  input  logic        i_Cke,
  input  logic [7:0]  i8_RxCodeGroup,
  input  logic        i_RxCodeCtrl,
  input  logic        i_RxCodeInvalid,
  input  logic        i_RxEven,
  input  logic        i_SyncStatus,
  input  logic        i_ClrErrCnt,
  output logic [7:0]  o8_GmiiRxd,
  output logic        o_GmiiRxDv,
  output logic        o_GmiiRxEr,
  output logic [15:0] o16_RxConfigReg,
  output logic        o_RxConfigValid,
  output logic        o_AbilityMatch,
  output logic        o_RxConfigActive,
  output logic        o_RxIdle,
  output logic [15:0] o16_CodeErrCnt
);

  localparam logic [7:0] L_K28_5 = 8'hBC;
  localparam logic [7:0] L_S     = 8'hFB;
  localparam logic [7:0] L_T     = 8'hFD;
  localparam logic [7:0] L_R     = 8'hF7;
  localparam logic [7:0] L_C1    = 8'hB5;
  localparam logic [7:0] L_C2    = 8'h42;
  localparam logic [7:0] L_I1    = 8'hC5;
  localparam logic [7:0] L_I2    = 8'h50;

  typedef enum logic [3:0] {
    StLinkFailed, StWaitK, StRxK, StRxCb, StRxCc, StIdleD, StReceive, StExtend, StFalseCarrier
  } state_e;

  state_e      r_State;
  logic [7:0]  r_CfgLow;
  logic [2:0]  r_MatchCnt;

  logic        w_Data, w_Kv, w_EvenComma, w_IsS, w_IsT, w_IsR, w_IsCfg, w_IsIdle;
  logic [15:0] w_Commit;
  logic [2:0]  w_MatchNext;

  assign w_Data      = !i_RxCodeInvalid && !i_RxCodeCtrl;
  assign w_Kv        = !i_RxCodeInvalid && i_RxCodeCtrl;
  assign w_EvenComma = w_Kv && (i8_RxCodeGroup == L_K28_5) && i_RxEven;
  assign w_IsS       = w_Kv && (i8_RxCodeGroup == L_S);
  assign w_IsT       = w_Kv && (i8_RxCodeGroup == L_T);
  assign w_IsR       = w_Kv && (i8_RxCodeGroup == L_R);
  assign w_IsCfg     = w_Data && ((i8_RxCodeGroup == L_C1) || (i8_RxCodeGroup == L_C2));
  assign w_IsIdle    = w_Data && ((i8_RxCodeGroup == L_I1) || (i8_RxCodeGroup == L_I2));
  assign w_Commit    = {i8_RxCodeGroup, r_CfgLow};

  // Run length of identical commits, restarting at 1 whenever the value changes.
  assign w_MatchNext = (w_Commit != o16_RxConfigReg) ? 3'd1 :
                       (r_MatchCnt == 3'd7)          ? 3'd7 : r_MatchCnt + 3'd1;

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      r_State          <= StLinkFailed;
      r_CfgLow         <= 8'h00;
      r_MatchCnt       <= 3'd0;
      o8_GmiiRxd       <= 8'h00;
      o_GmiiRxDv       <= 1'b0;
      o_GmiiRxEr       <= 1'b0;
      o16_RxConfigReg  <= 16'h0000;
      o_RxConfigValid  <= 1'b0;
      o_AbilityMatch   <= 1'b0;
      o_RxConfigActive <= 1'b0;
      o_RxIdle         <= 1'b0;
    end else if (i_Cke) begin
      o8_GmiiRxd      <= 8'h00;
      o_GmiiRxDv      <= 1'b0;
      o_GmiiRxEr      <= 1'b0;
      o_RxConfigValid <= 1'b0;
      if (!i_SyncStatus) begin
        // Losing sync mid-frame flags the truncated frame with a single error cycle.
        o_GmiiRxEr       <= (r_State == StReceive);
        r_State          <= StLinkFailed;
        r_MatchCnt       <= 3'd0;
        o_AbilityMatch   <= 1'b0;
        o_RxConfigActive <= 1'b0;
        o_RxIdle         <= 1'b0;
      end else begin
        case (r_State)
          StLinkFailed: r_State <= StWaitK;
          StWaitK: if (w_EvenComma) r_State <= StRxK;
          StRxK: begin
            if (w_IsCfg) begin
              r_State          <= StRxCb;
              o_RxConfigActive <= 1'b1;
              o_RxIdle         <= 1'b0;
            end else if (w_IsIdle) begin
              r_State          <= StIdleD;
              o_RxIdle         <= 1'b1;
              o_RxConfigActive <= 1'b0;
              r_MatchCnt       <= 3'd0;
              o_AbilityMatch   <= 1'b0;
            end else begin
              r_State <= StWaitK;
            end
          end
          StRxCb: begin
            if (w_Data) begin
              r_CfgLow <= i8_RxCodeGroup;
              r_State  <= StRxCc;
            end else begin
              r_State <= StWaitK;
            end
          end
          StRxCc: begin
            if (w_Data) begin
              o16_RxConfigReg <= w_Commit;
              o_RxConfigValid <= 1'b1;
              r_MatchCnt      <= w_MatchNext;
              o_AbilityMatch  <= ({29'd0, w_MatchNext} >= P_MATCH_CNT);
            end
            r_State <= StWaitK;
          end
          StIdleD: begin
            if (w_EvenComma) begin
              r_State <= StRxK;
            end else if (w_IsS) begin
              r_State    <= StReceive;
              o_GmiiRxDv <= 1'b1;
              o8_GmiiRxd <= 8'h55;
            end else begin
              r_State    <= StFalseCarrier;
              o_GmiiRxEr <= 1'b1;
              o8_GmiiRxd <= 8'h0E;
            end
          end
          StReceive: begin
            if (w_Data) begin
              o_GmiiRxDv <= 1'b1;
              o8_GmiiRxd <= i8_RxCodeGroup;
            end else if (w_IsT) begin
              r_State <= StExtend;
            end else if (w_EvenComma) begin
              r_State    <= StRxK;
              o_GmiiRxDv <= 1'b1;
              o_GmiiRxEr <= 1'b1;
            end else begin
              o_GmiiRxDv <= 1'b1;
              o_GmiiRxEr <= 1'b1;
              o8_GmiiRxd <= i8_RxCodeGroup;
            end
          end
          StExtend: begin
            if (w_IsR) begin
              o_GmiiRxEr <= 1'b1;
              o8_GmiiRxd <= 8'h0F;
            end else if (w_EvenComma) begin
              r_State <= StRxK;
            end else if (w_IsS) begin
              r_State    <= StReceive;
              o_GmiiRxDv <= 1'b1;
              o8_GmiiRxd <= 8'h55;
            end else begin
              r_State    <= StWaitK;
              o_GmiiRxEr <= 1'b1;
              o8_GmiiRxd <= 8'h1F;
            end
          end
          StFalseCarrier: begin
            if (w_EvenComma) begin
              r_State <= StRxK;
            end else begin
              o_GmiiRxEr <= 1'b1;
              o8_GmiiRxd <= 8'h0E;
            end
          end
          default: r_State <= StLinkFailed;
        endcase
      end
    end
  end

  // Clear bypasses the clock enable so software can reset the count at any time.
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      o16_CodeErrCnt <= 16'h0000;
    end else if (i_ClrErrCnt) begin
      o16_CodeErrCnt <= 16'h0000;
    end else if (i_Cke && i_RxCodeInvalid && i_SyncStatus && (o16_CodeErrCnt != 16'hFFFF)) begin
      o16_CodeErrCnt <= o16_CodeErrCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcs_rx_decode.sv
// Bench for pcs_rx_decode: directed scenarios followed by randomized traffic, every cycle
// compared against a behavioural receive model.
module tb_pcs_rx_decode;
  localparam int unsigned P = 3;

  logic        i_Clk = 1'b0;
  logic        i_ARst_L = 1'b0;
  logic        i_Cke = 1'b0;
  logic [7:0]  i8_RxCodeGroup = 8'h00;
  logic        i_RxCodeCtrl = 1'b0;
  logic        i_RxCodeInvalid = 1'b0;
  logic        i_RxEven = 1'b1;
  logic        i_SyncStatus = 1'b0;
  logic        i_ClrErrCnt = 1'b0;
  logic [7:0]  o8_GmiiRxd;
  logic        o_GmiiRxDv, o_GmiiRxEr, o_RxConfigValid, o_AbilityMatch;
  logic        o_RxConfigActive, o_RxIdle;
  logic [15:0] o16_RxConfigReg, o16_CodeErrCnt;

  pcs_rx_decode #(.P_MATCH_CNT(P)) dut (
    .i_Clk(i_Clk), .i_ARst_L(i_ARst_L), .i_Cke(i_Cke), .i8_RxCodeGroup(i8_RxCodeGroup),
    .i_RxCodeCtrl(i_RxCodeCtrl), .i_RxCodeInvalid(i_RxCodeInvalid), .i_RxEven(i_RxEven),
    .i_SyncStatus(i_SyncStatus), .i_ClrErrCnt(i_ClrErrCnt), .o8_GmiiRxd(o8_GmiiRxd),
    .o_GmiiRxDv(o_GmiiRxDv), .o_GmiiRxEr(o_GmiiRxEr), .o16_RxConfigReg(o16_RxConfigReg),
    .o_RxConfigValid(o_RxConfigValid), .o_AbilityMatch(o_AbilityMatch),
    .o_RxConfigActive(o_RxConfigActive), .o_RxIdle(o_RxIdle), .o16_CodeErrCnt(o16_CodeErrCnt)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic r_even = 1'b1;

  // Behavioural model: receive mode by name, plus the commits seen since the last match clear.
  string       m_st;
  logic [15:0] m_reg, m_err;
  logic [7:0]  m_low;
  logic [15:0] m_hist[$];
  logic [7:0]  e_rxd;
  logic        e_dv, e_er, e_cv, e_match, e_act, e_idle;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int run_len();
    int n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] == m_hist[m_hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_st = "LINK_FAILED";
    m_reg = 16'h0; m_err = 16'h0; m_low = 8'h0;
    m_hist.delete();
    e_rxd = 8'h0; e_dv = 0; e_er = 0; e_cv = 0; e_match = 0; e_act = 0; e_idle = 0;
  endtask

  task automatic model_edge();
    logic d, k, ec;
    logic [7:0] g;
    if (i_ClrErrCnt) m_err = 16'h0;
    else if (i_Cke && i_RxCodeInvalid && i_SyncStatus && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    if (!i_Cke) return;
    g  = i8_RxCodeGroup;
    d  = !i_RxCodeInvalid && !i_RxCodeCtrl;
    k  = !i_RxCodeInvalid && i_RxCodeCtrl;
    ec = k && g == 8'hBC && i_RxEven;
    e_rxd = 8'h0; e_dv = 0; e_er = 0; e_cv = 0;
    if (!i_SyncStatus) begin
      e_er = (m_st == "RECEIVE");
      m_st = "LINK_FAILED";
      m_hist.delete();
      e_act = 0; e_idle = 0;
    end else if (m_st == "LINK_FAILED") begin
      m_st = "WAIT_K";
    end else if (m_st == "WAIT_K") begin
      if (ec) m_st = "RX_K";
    end else if (m_st == "RX_K") begin
      if (d && (g == 8'hB5 || g == 8'h42)) begin
        m_st = "RX_CB"; e_act = 1; e_idle = 0;
      end else if (d && (g == 8'hC5 || g == 8'h50)) begin
        m_st = "IDLE_D"; e_act = 0; e_idle = 1; m_hist.delete();
      end else m_st = "WAIT_K";
    end else if (m_st == "RX_CB") begin
      if (d) begin m_low = g; m_st = "RX_CC"; end
      else m_st = "WAIT_K";
    end else if (m_st == "RX_CC") begin
      if (d) begin m_reg = {g, m_low}; e_cv = 1; m_hist.push_back(m_reg); end
      m_st = "WAIT_K";
    end else if (m_st == "IDLE_D") begin
      if (ec) m_st = "RX_K";
      else if (k && g == 8'hFB) begin m_st = "RECEIVE"; e_dv = 1; e_rxd = 8'h55; end
      else begin m_st = "FALSE_CARRIER"; e_er = 1; e_rxd = 8'h0E; end
    end else if (m_st == "RECEIVE") begin
      if (d) begin e_dv = 1; e_rxd = g; end
      else if (k && g == 8'hFD) m_st = "EXTEND";
      else if (ec) begin m_st = "RX_K"; e_dv = 1; e_er = 1; end
      else begin e_dv = 1; e_er = 1; e_rxd = g; end
    end else if (m_st == "EXTEND") begin
      if (k && g == 8'hF7) begin e_er = 1; e_rxd = 8'h0F; end
      else if (ec) m_st = "RX_K";
      else if (k && g == 8'hFB) begin m_st = "RECEIVE"; e_dv = 1; e_rxd = 8'h55; end
      else begin m_st = "WAIT_K"; e_er = 1; e_rxd = 8'h1F; end
    end else begin
      if (ec) m_st = "RX_K";
      else begin e_er = 1; e_rxd = 8'h0E; end
    end
    e_match = (run_len() >= int'(P));
  endtask

  task automatic check_all();
    chk("rxd", 16'(o8_GmiiRxd), 16'(e_rxd));
    chk("rx_dv", 16'(o_GmiiRxDv), 16'(e_dv));
    chk("rx_er", 16'(o_GmiiRxEr), 16'(e_er));
    chk("cfg_reg", o16_RxConfigReg, m_reg);
    chk("cfg_valid", 16'(o_RxConfigValid), 16'(e_cv));
    chk("ability_match", 16'(o_AbilityMatch), 16'(e_match));
    chk("cfg_active", 16'(o_RxConfigActive), 16'(e_act));
    chk("rx_idle", 16'(o_RxIdle), 16'(e_idle));
    chk("err_cnt", o16_CodeErrCnt, m_err);
  endtask

  task automatic step(input logic c, input logic [7:0] g, input logic inv);
    i_RxCodeCtrl = c; i8_RxCodeGroup = g; i_RxCodeInvalid = inv; i_RxEven = r_even;
    @(posedge i_Clk);
    model_edge();
    if (i_Cke) r_even = ~r_even;
    #1;
    check_all();
  endtask

  task automatic idle2();
    step(1'b1, 8'hBC, 1'b0);
    step(1'b0, 8'h50, 1'b0);
  endtask

  task automatic send_cfg(input logic [7:0] c, input logic [15:0] r);
    step(1'b1, 8'hBC, 1'b0);
    step(1'b0, c, 1'b0);
    step(1'b0, r[7:0], 1'b0);
    step(1'b0, r[15:8], 1'b0);
  endtask

  task automatic rand_frame(input int len);
    step(1'b1, 8'hFB, 1'b0);
    for (int i = 0; i < len; i++) step(1'b0, 8'($urandom), 1'b0);
    step(1'b1, 8'hFD, 1'b0);
    step(1'b1, 8'hF7, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #12;
    chk("reset_dv", 16'(o_GmiiRxDv), 16'd0);
    chk("reset_errcnt", o16_CodeErrCnt, 16'd0);
    check_all();
    @(posedge i_Clk); #1;
    i_ARst_L = 1'b1; i_Cke = 1'b1; i_SyncStatus = 1'b1;

    // Idle stream, then a short frame with carrier extension.
    repeat (4) idle2();
    chk("idle_up", 16'(o_RxIdle), 16'd1);
    step(1'b1, 8'hFB, 1'b0); chk("pre_dv", 16'(o_GmiiRxDv), 16'd1); chk("pre", 16'(o8_GmiiRxd), 16'h55);
    step(1'b0, 8'h11, 1'b0); chk("d11", 16'(o8_GmiiRxd), 16'h11);
    step(1'b0, 8'h22, 1'b0); chk("d22", 16'(o8_GmiiRxd), 16'h22);
    step(1'b0, 8'h33, 1'b0); chk("d33", 16'(o8_GmiiRxd), 16'h33); chk("d33_dv", 16'(o_GmiiRxDv), 16'd1);
    step(1'b1, 8'hFD, 1'b0); chk("t_dv", 16'(o_GmiiRxDv), 16'd0); chk("t_er", 16'(o_GmiiRxEr), 16'd0);
    step(1'b1, 8'hF7, 1'b0); chk("r_er", 16'(o_GmiiRxEr), 16'd1); chk("r_rxd", 16'(o8_GmiiRxd), 16'h0F);
    idle2();
    chk("idle_kept", 16'(o_RxIdle), 16'd1);

    // Configuration: three identical registers reach ability match; a new value drops it.
    for (int i = 0; i < 3; i++) begin
      send_cfg(8'hB5, 16'h01A0);
      chk("cfg_pulse", 16'(o_RxConfigValid), 16'd1);
      chk("cfg_val", o16_RxConfigReg, 16'h01A0);
      chk("cfg_match", 16'(o_AbilityMatch), (i == 2) ? 16'd1 : 16'd0);
    end
    chk("cfg_active_on", 16'(o_RxConfigActive), 16'd1);
    send_cfg(8'h42, 16'h41A0);
    chk("cfg_new", o16_RxConfigReg, 16'h41A0);
    chk("match_drop", 16'(o_AbilityMatch), 16'd0);
    idle2();

    // Invalid code group inside a frame, then error-count clear.
    step(1'b1, 8'hFB, 1'b0);
    step(1'b0, 8'h11, 1'b0);
    step(1'b0, 8'h99, 1'b1);
    chk("inv_dv", 16'(o_GmiiRxDv), 16'd1); chk("inv_er", 16'(o_GmiiRxEr), 16'd1);
    chk("inv_cnt", o16_CodeErrCnt, 16'd1);
    step(1'b0, 8'h33, 1'b0); chk("inv_er_off", 16'(o_GmiiRxEr), 16'd0);
    step(1'b1, 8'hFD, 1'b0);
    step(1'b1, 8'hF7, 1'b0);
    i_ClrErrCnt = 1'b1;
    step(1'b1, 8'hBC, 1'b0);
    i_ClrErrCnt = 1'b0;
    chk("cnt_clr", o16_CodeErrCnt, 16'd0);
    step(1'b0, 8'h50, 1'b0);

    // False carrier from idle.
    step(1'b0, 8'h44, 1'b0);
    chk("fc_er", 16'(o_GmiiRxEr), 16'd1); chk("fc_rxd", 16'(o8_GmiiRxd), 16'h0E);
    chk("fc_dv", 16'(o_GmiiRxDv), 16'd0);
    step(1'b0, 8'h55, 1'b0); chk("fc_hold", 16'(o8_GmiiRxd), 16'h0E);
    step(1'b1, 8'hBC, 1'b0); chk("fc_end", 16'(o_GmiiRxEr), 16'd0);
    step(1'b0, 8'h50, 1'b0);

    // Sync loss during configuration, then during a frame.
    repeat (3) send_cfg(8'hB5, 16'h01A0);
    chk("resync_match", 16'(o_AbilityMatch), 16'd1);
    i_SyncStatus = 1'b0;
    step(1'b1, 8'hBC, 1'b0);
    chk("lf_match", 16'(o_AbilityMatch), 16'd0); chk("lf_act", 16'(o_RxConfigActive), 16'd0);
    chk("lf_reg", o16_RxConfigReg, 16'h01A0);
    step(1'b0, 8'h50, 1'b0);
    i_SyncStatus = 1'b1;
    repeat (2) idle2();
    step(1'b1, 8'hFB, 1'b0);
    step(1'b0, 8'h11, 1'b0);
    i_SyncStatus = 1'b0;
    step(1'b0, 8'h22, 1'b0);
    chk("drop_dv", 16'(o_GmiiRxDv), 16'd0); chk("drop_er", 16'(o_GmiiRxEr), 16'd1);
    step(1'b0, 8'h33, 1'b0);
    chk("drop_er2", 16'(o_GmiiRxEr), 16'd0); chk("drop_reg", o16_RxConfigReg, 16'h01A0);
    i_SyncStatus = 1'b1;
    repeat (2) idle2();

    // Clock enable low for five cycles mid-frame.
    step(1'b1, 8'hFB, 1'b0);
    step(1'b0, 8'h11, 1'b0);
    i_Cke = 1'b0;
    repeat (5) begin
      step(1'b1, 8'hEE, 1'b0);
      chk("cke_hold", 16'(o8_GmiiRxd), 16'h11);
    end
    i_Cke = 1'b1;
    step(1'b0, 8'h22, 1'b0); chk("cke_d22", 16'(o8_GmiiRxd), 16'h22);
    step(1'b0, 8'h33, 1'b0); chk("cke_d33", 16'(o8_GmiiRxd), 16'h33);
    step(1'b1, 8'hFD, 1'b0);
    step(1'b1, 8'hF7, 1'b0);
    idle2();

    // Asynchronous reset in the middle of a frame.
    step(1'b1, 8'hFB, 1'b0);
    step(1'b0, 8'h11, 1'b0);
    #2 i_ARst_L = 1'b0;
    #1 model_reset();
    chk("arst_dv", 16'(o_GmiiRxDv), 16'd0); chk("arst_er", 16'(o_GmiiRxEr), 16'd0);
    check_all();
    #1 i_ARst_L = 1'b1;
    r_even = 1'b1;
    repeat (2) idle2();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      if ($urandom_range(0, 199) == 0) i_SyncStatus = 1'b0;
      else if (!i_SyncStatus && $urandom_range(0, 3) == 0) i_SyncStatus = 1'b1;
      i_Cke = ($urandom_range(0, 7) != 0);
      i_ClrErrCnt = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) r_even = ~r_even;
      sel = $urandom_range(0, 19);
      case (sel)
        0, 1, 2: step(1'b1, 8'hBC, 1'b0);
        3:       step(1'b0, 8'h50, 1'b0);
        4:       step(1'b0, 8'hC5, 1'b0);
        5:       step(1'b1, 8'hFB, 1'b0);
        6:       step(1'b1, 8'hFD, 1'b0);
        7:       step(1'b1, 8'hF7, 1'b0);
        8:       step(1'b1, 8'hFE, 1'b0);
        9:       step(1'($urandom), 8'($urandom), 1'b1);
        10, 11, 12: send_cfg(($urandom_range(0, 1) != 0) ? 8'hB5 : 8'h42,
                             ($urandom_range(0, 3) != 0) ? 16'h01A0 : 16'h41A0);
        13, 14:  rand_frame($urandom_range(1, 6));
        15, 16:  idle2();
        default: step(1'b0, 8'($urandom), 1'b0);
      endcase
    end
    i_ClrErrCnt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
